// File: rtl/moi.sv
// rtl/moi.sv - Q-table max/argmax lookup over four road BRAMs
//
// Ports:
//   clk, rst           clock (rising edge), synchronous active-high reset
//   req_valid/ready    request handshake; S is the state to look up
//   rd_addr, ren       shared BRAM read address (S<<2) and one-cycle read enable
//   D_road0..3         BRAM read data, one Q_WIDTH value per level
//   out_valid/ready    result handshake
//   Q_max, A_max       maximum signed Q and its action {road, dur}
//   S_out              state that produced the result
module moi #(
    parameter int L_WIDTH    = 4,
    parameter int Q_WIDTH    = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int RD_LAT     = 2,
    localparam int N_LEVEL   = 2 ** (L_WIDTH / 2),
    localparam int S_WIDTH   = 2 * L_WIDTH,
    localparam int D_WIDTH   = Q_WIDTH * N_LEVEL,
    localparam int A_WIDTH   = 2 + L_WIDTH / 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [S_WIDTH-1:0]    S,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  ren,
    input  logic [D_WIDTH-1:0]    D_road0,
    input  logic [D_WIDTH-1:0]    D_road1,
    input  logic [D_WIDTH-1:0]    D_road2,
    input  logic [D_WIDTH-1:0]    D_road3,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [Q_WIDTH-1:0]    Q_max,
    output logic [A_WIDTH-1:0]    A_max,
    output logic [S_WIDTH-1:0]    S_out
);

    localparam int N_ELEM = 4 * N_LEVEL;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_READ = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    logic [1:0]         state;
    logic [2:0]         cnt;
    logic [A_WIDTH-1:0] k;
    logic [Q_WIDTH-1:0] best_q;
    logic [A_WIDTH-1:0] best_a;

    // Element index {road, dur} is exactly the flattened road-major index,
    // so the scan simply walks elems[k].
    logic [Q_WIDTH-1:0] elems [N_ELEM];
    logic [D_WIDTH-1:0] road_data [4];

    logic               capture;
    logic [Q_WIDTH-1:0] elem;
    logic               greater;
    logic [Q_WIDTH-1:0] nxt_q;
    logic [A_WIDTH-1:0] nxt_a;
    logic [ADDR_WIDTH-1:0] addr_ext;

    assign road_data[0] = D_road0;
    assign road_data[1] = D_road1;
    assign road_data[2] = D_road2;
    assign road_data[3] = D_road3;

    assign req_ready = (state == ST_IDLE) && !rst;
    assign capture   = (state == ST_READ) && (cnt == 3'(RD_LAT));
    assign addr_ext  = ADDR_WIDTH'({S, 2'b00});

    always_comb begin
        elem    = elems[k];
        greater = $signed(elem) > $signed(best_q);
        nxt_q   = greater ? elem : best_q;
        nxt_a   = greater ? k : best_a;
    end

    // Data buffer needs no reset: it is only read after a fresh capture.
    always_ff @(posedge clk) begin
        if (!rst && capture) begin
            for (int r = 0; r < 4; r++) begin
                for (int d = 0; d < N_LEVEL; d++) begin
                    elems[r*N_LEVEL+d] <= road_data[r][d*Q_WIDTH +: Q_WIDTH];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            ren       <= 1'b0;
            rd_addr   <= '0;
            S_out     <= '0;
            Q_max     <= '0;
            A_max     <= '0;
            out_valid <= 1'b0;
            cnt       <= '0;
            k         <= '0;
            best_q    <= '0;
            best_a    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        S_out   <= S;
                        rd_addr <= addr_ext;
                        ren     <= 1'b1;
                        cnt     <= '0;
                        state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    ren <= 1'b0;
                    if (capture) begin
                        best_q <= D_road0[Q_WIDTH-1:0];
                        best_a <= '0;
                        k      <= A_WIDTH'(1);
                        state  <= ST_SCAN;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ST_SCAN: begin
                    best_q <= nxt_q;
                    best_a <= nxt_a;
                    k      <= k + A_WIDTH'(1);
                    if (k == {A_WIDTH{1'b1}}) begin
                        // Results become visible only here, never mid-scan.
                        Q_max     <= nxt_q;
                        A_max     <= nxt_a;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_moi.sv
// tb/tb_moi.sv - randomized self-checking bench for moi against a max/argmax model
module tb_moi;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  s_in;
    logic [31:0] rd_addr;
    logic        ren;
    logic [63:0] droad [4];
    logic        out_valid;
    logic        out_ready;
    logic [15:0] q_max;
    logic [3:0]  a_max;
    logic [7:0]  s_out;

    int n_checks = 0;
    int n_err    = 0;

    logic [15:0] qtab [256][16];

    // BRAM model: RD_LAT-cycle read pipeline, random junk whenever data is not valid
    logic [RD_LAT-1:0] pipe;
    logic [7:0]        spipe [RD_LAT];
    logic [63:0]       garb [4];

    always_comb pipe[0] = 1'b0;

    moi #(.L_WIDTH(4), .Q_WIDTH(16), .ADDR_WIDTH(32), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .S(s_in), .rd_addr(rd_addr), .ren(ren),
        .D_road0(droad[0]), .D_road1(droad[1]), .D_road2(droad[2]), .D_road3(droad[3]),
        .out_valid(out_valid), .out_ready(out_ready),
        .Q_max(q_max), .A_max(a_max), .S_out(s_out)
    );

    always #5 clk = ~clk;

    logic [RD_LAT-1:0] vpipe = '0;
    always @(posedge clk) begin
        vpipe[0] <= ren;
        spipe[0] <= rd_addr[9:2];
        for (int i = 1; i < RD_LAT; i++) begin
            vpipe[i] <= vpipe[i-1];
            spipe[i] <= spipe[i-1];
        end
        for (int r = 0; r < 4; r++) garb[r] <= {$urandom, $urandom};
    end

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            for (int d = 0; d < 4; d++) begin
                droad[r][d*16 +: 16] = vpipe[RD_LAT-1] ? qtab[spipe[RD_LAT-1]][r*4+d]
                                                       : garb[r][d*16 +: 16];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [15:0] prev_q = '0;
    logic [3:0]  prev_a = '0;

    // Reference: largest signed value, then the first action holding it.
    task automatic model(input logic [7:0] s, output logic [15:0] eq, output logic [3:0] ea);
        int maxv;
        maxv = -40000;
        for (int i = 0; i < 16; i++)
            if (int'($signed(qtab[s][i])) > maxv) maxv = int'($signed(qtab[s][i]));
        ea = 4'h0;
        for (int i = 15; i >= 0; i--)
            if (int'($signed(qtab[s][i])) == maxv) ea = 4'(i);
        eq = 16'(maxv);
    endtask

    task automatic fill_random(input logic [7:0] s);
        int mode;
        mode = $urandom_range(0, 2);
        for (int i = 0; i < 16; i++) begin
            case (mode)
                0: qtab[s][i] = 16'($urandom);
                1: qtab[s][i] = 16'($signed($urandom_range(0, 6)) - 3);
                default: qtab[s][i] = 16'($urandom) | 16'h8000;
            endcase
        end
    endtask

    // Caller is at a negedge with the DUT idle. rst_at > 0 pulses reset
    // at that many cycles after acceptance instead of completing.
    task automatic run_req(input logic [7:0] s, input int hold, input int rst_at);
        logic [15:0] eq;
        logic [3:0]  ea;
        int cyc, ren_cnt;
        logic ok;
        model(s, eq, ea);
        s_in = s;
        req_valid = 1'b1;
        #1 check("req_ready_idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        s_in = s ^ 8'hA5;
        check("ren_first", 32'(ren), 32'd1);
        check("rd_addr", rd_addr, {22'd0, s, 2'b00});
        check("s_out_accept", 32'(s_out), 32'(s));
        check("req_ready_busy", 32'(req_ready), 32'd0);
        ren_cnt = 1;
        cyc = 0;
        ok = 1'b1;
        while (!out_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
            if (ren) ren_cnt++;
            if (!out_valid && (q_max !== prev_q || a_max !== prev_a || s_out !== s ||
                rd_addr !== {22'd0, s, 2'b00} || req_ready !== 1'b0)) ok = 1'b0;
            if (cyc == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                req_valid = 1'b0;
                #1;
                check("rst_out_valid", 32'(out_valid), 32'd0);
                check("rst_ren", 32'(ren), 32'd0);
                check("rst_req_ready", 32'(req_ready), 32'd1);
                check("rst_outputs", {rd_addr[15:0], q_max[7:0], a_max, s_out[3:0]}, 32'd0);
                check("rst_more", {q_max[15:8], s_out[7:4]}, 32'd0);
                prev_q = '0;
                prev_a = '0;
                return;
            end
        end
        check("latency", 32'(cyc), 32'(RD_LAT + 16));
        check("ren_once", 32'(ren_cnt), 32'd1);
        check("busy_stable", 32'(ok), 32'd1);
        check("q_max", 32'(q_max), 32'(eq));
        check("a_max", 32'(a_max), 32'(ea));
        check("s_out_done", 32'(s_out), 32'(s));
        ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            s_in = 8'($urandom);
            @(negedge clk);
            if (out_valid !== 1'b1 || q_max !== eq || a_max !== ea || s_out !== s ||
                req_ready !== 1'b0) ok = 1'b0;
        end
        check("done_hold", 32'(ok), 32'd1);
        req_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_ready", 32'(req_ready), 32'd1);
        prev_q = eq;
        prev_a = ea;
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 1'b0;
        out_ready = 1'b0;
        s_in = '0;
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < 16; j++) qtab[i][j] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_ready", 32'(req_ready), 32'd1);
        check("reset_valid", 32'(out_valid), 32'd0);
        check("reset_ren", 32'(ren), 32'd0);
        check("reset_outs", {rd_addr[19:0], q_max[3:0], a_max, s_out[3:0]}, 32'd0);
        @(negedge clk);

        for (int j = 0; j < 16; j++) qtab[8'h05][j] = '0;
        qtab[8'h05][9] = 16'sd100;
        run_req(8'h05, 5, 0);

        for (int j = 0; j < 16; j++) qtab[8'h3C][j] = 16'hFFF0;
        qtab[8'h3C][7] = 16'hFFFF;
        run_req(8'h3C, 1, 0);

        for (int j = 0; j < 16; j++) qtab[8'hFF][j] = 16'sd50;
        run_req(8'hFF, 0, 0);

        fill_random(8'h12);
        run_req(8'h12, 0, 8);
        fill_random(8'h12);
        run_req(8'h12, 2, 0);

        for (int n = 0; n < 25; n++) begin
            logic [7:0] s;
            s = 8'($urandom);
            fill_random(s);
            run_req(s, $urandom_range(0, 3), 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
